// File: rtl/iter_alu.sv
// Iterative W-bit ALU: add/sub, radix-2 Booth multiply, restoring divide, signed or unsigned.
// Latency from accept edge to done: add/sub and divide-by-zero 2 cycles, mul/div W+2 cycles.
// Accepts start only while idle; start and operand changes while busy or in the done cycle are ignored.
// Optional macro ITER_ALU_SAT_EN: add/sub saturate on overflow instead of wrapping.
module iter_alu #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         sign,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result_lo,
    output logic [W-1:0] result_hi,
    output logic         ovf,
    output logic         dz
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDSUB,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic           sign_q, sign_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W:0]     acc_q, acc_d;     // Booth accumulator / division partial remainder
    logic [W:0]     mq_q, mq_d;       // Booth multiplier / division quotient (low W bits)
    logic           qm1_q, qm1_d;     // Booth q[-1] bit
    logic           dzp_q, dzp_d;     // divide-by-zero pending for this operation
    logic [W-1:0]   res_lo_q, res_lo_d;
    logic [W-1:0]   res_hi_q, res_hi_d;
    logic           ovf_q, ovf_d;
    logic           dz_q, dz_d;

    logic [W-1:0]   as_lo, as_hi;
    logic           as_ovf;
    logic [W:0]     as_ext_a, as_ext_b, as_sum;

    logic [W:0]     mcand, booth_sum, booth_acc, booth_mq;
    logic           booth_qm1;
    logic [W-1:0]   mul_lo, mul_hi;
    logic           mul_ovf;

    logic [W-1:0]   abs_b, in_abs_a;
    logic [W:0]     div_sh_r, div_acc, div_mq;
    logic [W+1:0]   div_trial;
    logic           q_neg, r_neg;
    logic [W-1:0]   div_lo, div_hi;
    logic           div_ovf;

    // Add/sub: one (W+1)-bit sum gives the carry/borrow (unsigned) or the true sign (signed).
    always_comb begin
        as_ext_a = {sign_q & a_q[W-1], a_q};
        as_ext_b = {sign_q & b_q[W-1], b_q};
        as_sum   = (op_q == OP_SUB) ? (as_ext_a - as_ext_b) : (as_ext_a + as_ext_b);
        as_lo    = as_sum[W-1:0];
        if (sign_q) begin
            as_hi  = {W{as_sum[W]}};
            as_ovf = as_sum[W] ^ as_sum[W-1];
        end else begin
            as_hi  = {{(W-1){1'b0}}, as_sum[W]};
            as_ovf = as_sum[W];
        end
`ifdef ITER_ALU_SAT_EN
        if (as_ovf) begin
            if (sign_q) begin
                as_lo = as_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                as_hi = {W{as_lo[W-1]}};
            end else begin
                as_lo = (op_q == OP_SUB) ? {W{1'b0}} : {W{1'b1}};
                as_hi = {W{1'b0}};
            end
        end
`endif
    end

    // Booth step on (W+1)-bit operands; product taken from the post-step values so the
    // final step's result is captured on the same edge that enters FIN.
    always_comb begin
        mcand = {sign_q & a_q[W-1], a_q};
        case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand;
            2'b10:   booth_sum = acc_q - mcand;
            default: booth_sum = acc_q;
        endcase
        booth_acc = {booth_sum[W], booth_sum[W:1]};
        booth_mq  = {booth_sum[0], mq_q[W:1]};
        booth_qm1 = mq_q[0];
        mul_lo    = booth_mq[W-1:0];
        mul_hi    = {booth_acc[W-2:0], booth_mq[W]};
        mul_ovf   = sign_q ? (mul_hi != {W{mul_lo[W-1]}}) : (mul_hi != {W{1'b0}});
    end

    // Restoring divide step on magnitudes, plus sign correction of the finished quotient/remainder.
    always_comb begin
        in_abs_a  = (sign && a[W-1]) ? -a : a;
        abs_b     = (sign_q && b_q[W-1]) ? -b_q : b_q;
        div_sh_r  = {acc_q[W-1:0], mq_q[W-1]};
        div_trial = {1'b0, div_sh_r} - {2'b00, abs_b};
        div_acc   = div_trial[W+1] ? div_sh_r : div_trial[W:0];
        div_mq    = {1'b0, mq_q[W-2:0], ~div_trial[W+1]};
        q_neg     = sign_q & (a_q[W-1] ^ b_q[W-1]);
        r_neg     = sign_q & a_q[W-1];
        div_lo    = q_neg ? -mq_q[W-1:0] : mq_q[W-1:0];
        div_hi    = r_neg ? -acc_q[W-1:0] : acc_q[W-1:0];
        // Only -2^(W-1) / -1 yields a positive magnitude of 2^(W-1).
        div_ovf   = sign_q & ~q_neg & mq_q[W-1];
    end

    // Control FSM: operand capture, per-state iteration, result capture on entry to FIN.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        qm1_d    = qm1_q;
        dzp_d    = dzp_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    sign_d = sign;
                    a_d    = a;
                    b_d    = b;
                    cnt_d  = '0;
                    acc_d  = '0;
                    qm1_d  = 1'b0;
                    dzp_d  = 1'b0;
                    mq_d   = '0;
                    if (op == OP_ADD || op == OP_SUB) begin
                        state_d = S_ADDSUB;
                    end else if (op == OP_MUL) begin
                        mq_d    = {sign & b[W-1], b};
                        state_d = S_MUL;
                    end else begin
                        mq_d    = {1'b0, in_abs_a};
                        dzp_d   = (b == '0);
                        state_d = S_DIV;
                    end
                end
            end
            S_ADDSUB: begin
                res_lo_d = as_lo;
                res_hi_d = as_hi;
                ovf_d    = as_ovf;
                dz_d     = 1'b0;
                state_d  = S_FIN;
            end
            S_MUL: begin
                // W+1 steps, one per bit of the extended multiplier.
                acc_d = booth_acc;
                mq_d  = booth_mq;
                qm1_d = booth_qm1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W)) begin
                    res_lo_d = mul_lo;
                    res_hi_d = mul_hi;
                    ovf_d    = mul_ovf;
                    dz_d     = 1'b0;
                    state_d  = S_FIN;
                end
            end
            S_DIV: begin
                // Divide-by-zero spends one cycle here with no iterations so its timing
                // matches add/sub; otherwise W quotient bits then one sign-fix cycle.
                if (dzp_q) begin
                    res_lo_d = {W{1'b1}};
                    res_hi_d = a_q;
                    ovf_d    = 1'b0;
                    dz_d     = 1'b1;
                    state_d  = S_FIN;
                end else if (cnt_q == CW'(W)) begin
                    res_lo_d = div_lo;
                    res_hi_d = div_hi;
                    ovf_d    = div_ovf;
                    dz_d     = 1'b0;
                    state_d  = S_FIN;
                end else begin
                    acc_d = div_acc;
                    mq_d  = div_mq;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any operation and clears outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sign_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            qm1_q    <= 1'b0;
            dzp_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            qm1_q    <= qm1_d;
            dzp_q    <= dzp_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_iter_alu.sv
// Testbench for iter_alu (W=8): directed vectors plus random operations against an
// integer-arithmetic reference model; checks results, flags, done timing and handshake.
module tb_iter_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         sign = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, ovf, dz;
    logic [W-1:0] result_lo, result_hi;

    always #5 clk = ~clk;

    iter_alu #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .sign      (sign),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .ovf       (ovf),
        .dz        (dz)
    );

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_lo, exp_hi, prev_lo;
    logic         exp_ovf, exp_dz;
    int           exp_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce to W-bit fields.
    task automatic model(input logic [1:0] o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, r, q, rm, lim_lo, lim_hi;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        lim_lo = s ? -(longint'(1) << (W - 1)) : 0;
        lim_hi = s ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
        exp_dz = 1'b0;
        case (o)
            2'b00, 2'b01: begin
                r = (o == 2'b00) ? sx + sy : sx - sy;
                exp_lat = 2;
                exp_ovf = (r < lim_lo) || (r > lim_hi);
                exp_lo  = r[W-1:0];
                if (s) exp_hi = (r < 0) ? '1 : '0;
                else   exp_hi = exp_ovf ? W'(1) : W'(0);
`ifdef ITER_ALU_SAT_EN
                if (exp_ovf) begin
                    if (s) begin
                        exp_lo = (r < 0) ? lim_lo[W-1:0] : lim_hi[W-1:0];
                        exp_hi = (r < 0) ? '1 : '0;
                    end else begin
                        exp_lo = (r < 0) ? '0 : '1;
                        exp_hi = '0;
                    end
                end
`endif
            end
            2'b10: begin
                r = sx * sy;
                exp_lat = W + 2;
                exp_lo  = r[W-1:0];
                exp_hi  = r[2*W-1:W];
                exp_ovf = (r < lim_lo) || (r > lim_hi);
            end
            default: begin
                if (y == '0) begin
                    exp_lat = 2;
                    exp_dz  = 1'b1;
                    exp_lo  = '1;
                    exp_hi  = x;
                    exp_ovf = 1'b0;
                end else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    exp_lat = W + 2;
                    exp_lo  = q[W-1:0];
                    exp_hi  = rm[W-1:0];
                    exp_ovf = (q < lim_lo) || (q > lim_hi);
                end
            end
        endcase
    endtask

    // Present an operation with start high; called just after a falling edge.
    task automatic drive(input logic [1:0] o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; sign = s; a = x; b = y; start = 1'b1;
        model(o, s, x, y);
    endtask

    // Step past the accept edge, then scramble inputs (the DUT must ignore them).
    task automatic launch(input logic [1:0] o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        drive(o, s, x, y);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); sign = 1'($urandom); a = W'($urandom); b = W'($urandom);
    endtask

    // Entered at cycle 1 after accept; waits (bounded) for done and checks everything there.
    task automatic wait_done(input string tag, input int pulse_at);
        int cyc;
        bit seen;
        cyc = 1;
        seen = 0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_hold"}, 32'(result_lo), 32'(prev_lo));
        while (cyc <= 60) begin
            if (done) begin
                seen = 1;
                break;
            end
            start = (cyc == pulse_at);
            if (start) begin
                op = 2'($urandom); sign = 1'($urandom); a = W'($urandom); b = W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_lat"}, seen ? 32'(cyc) : 32'd0, 32'(exp_lat));
        if (seen) begin
            check({tag, "_lo"},  32'(result_lo), 32'(exp_lo));
            check({tag, "_hi"},  32'(result_hi), 32'(exp_hi));
            check({tag, "_ovf"}, 32'(ovf),       32'(exp_ovf));
            check({tag, "_dz"},  32'(dz),        32'(exp_dz));
        end
        prev_lo = exp_lo;
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic s,
                       input logic [W-1:0] x, input logic [W-1:0] y, input int pulse_at);
        launch(o, s, x, y);
        wait_done(tag, pulse_at);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"},  32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        logic [1:0] ro;
        prev_lo = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lo",   32'(result_lo), 32'd0);
        check("rst_hi",   32'(result_hi), 32'd0);
        check("rst_ovf",  32'(ovf), 32'd0);
        check("rst_dz",   32'(dz), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run("sadd_100_50",  2'b00, 1'b1, 8'd100, 8'd50, 0);
        run("smul_m128sq",  2'b10, 1'b1, 8'h80, 8'h80, 0);
        run("umul_255sq",   2'b10, 1'b0, 8'hFF, 8'hFF, 0);
        run("udiv_200_7",   2'b11, 1'b0, 8'd200, 8'd7, 0);
        run("sdiv_m7_2",    2'b11, 1'b1, 8'hF9, 8'd2, 0);
        run("sdiv_m128_m1", 2'b11, 1'b1, 8'h80, 8'hFF, 0);
        run("div_5_0",      2'b11, 1'b0, 8'd5, 8'd0, 0);
        run("usub_3_5",     2'b01, 1'b0, 8'd3, 8'd5, 0);
        run("ssub_m128_1",  2'b01, 1'b1, 8'h80, 8'd1, 0);
        run("uadd_200_100", 2'b00, 1'b0, 8'd200, 8'd100, 0);
        run("smul_midstart", 2'b10, 1'b1, 8'hB5, 8'h3C, 3);

        // start held in the done cycle is ignored, then accepted in the following idle cycle
        launch(2'b00, 1'b0, 8'd1, 8'd2);
        wait_done("sid_first", 0);
        drive(2'b00, 1'b0, 8'd10, 8'd20);
        @(negedge clk);
        check("sid_ignored_busy", 32'(busy), 32'd0);
        check("sid_ignored_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done("sid_second", 0);
        @(negedge clk);

        // reset in the middle of a multiply aborts it
        launch(2'b10, 1'b1, 8'h7B, 8'hC3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_lo",   32'(result_lo), 32'd0);
        check("abort_hi",   32'(result_hi), 32'd0);
        check("abort_ovf",  32'(ovf), 32'd0);
        check("abort_dz",   32'(dz), 32'd0);
        rst = 1'b0;
        prev_lo = '0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] rb;
            ro = 2'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            launch(ro, 1'($urandom), W'($urandom), rb);
            wait_done($sformatf("rnd%0d", i), $urandom_range(0, exp_lat - 1));
            @(negedge clk);
            check($sformatf("rnd%0d_idle", i), 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
